// File: rtl/decrypt_sequencer.sv
// decrypt_sequencer: fills a character buffer from rx, writes it into the processor
// wrapper, runs the program until done_flag or timeout, then streams RAM results to tx.
// One job at a time; rx and tx are valid/ready handshakes, tx_data held until accepted.
module decrypt_sequencer #(
  parameter int BUF_LEN        = 108,
  parameter int RAM_BASE       = 1500,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode_in,
  input  logic [4:0]  shift_in,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  char_buffer_data,
  output logic [1:0]  cpu_en,
  output logic [1:0]  program_sel,
  output logic [4:0]  shift_amt_data,
  input  logic        done_flag,
  output logic [11:0] read_addr,
  input  logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        job_done,
  output logic        timeout
);

  localparam int IDX_W  = ($clog2(BUF_LEN + 1) > 7) ? $clog2(BUF_LEN + 1) : 7;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BUF_AW = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BUF_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0]      RAM_BASE12 = 12'(RAM_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_EXEC, S_RDADDR, S_RDWAIT, S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [4:0]        shift_q, shift_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              job_done_q, job_done_d;

  logic [7:0]        buf_mem [BUF_LEN];
  logic [BUF_AW-1:0] buf_addr;
  logic              start_ok;

  // Only the low result byte of each RAM word is forwarded.
  logic unused_read_hi;
  assign unused_read_hi = ^read_data[31:8];

  assign buf_addr = idx_q[BUF_AW-1:0];
  assign start_ok = start && ((mode_in == 2'b01) || (mode_in == 2'b10));

  // Character buffer: written only while filling; no reset needed since reads are gated by state.
  always_ff @(posedge clock) begin
    if (state_q == S_FILL && rx_valid) begin
      buf_mem[buf_addr] <= rx_data;
    end
  end

  // State and datapath registers; reset aborts any job and clears every flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      shift_q    <= '0;
      timeout_q  <= 1'b0;
      tx_data_q  <= '0;
      job_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      shift_q    <= shift_d;
      timeout_q  <= timeout_d;
      tx_data_q  <= tx_data_d;
      job_done_q <= job_done_d;
    end
  end

  // Next-state and datapath updates; done_flag has priority over the timeout limit.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    shift_d    = shift_q;
    timeout_d  = timeout_q;
    tx_data_d  = tx_data_q;
    job_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          mode_d    = mode_in;
          shift_d   = shift_in;
          timeout_d = 1'b0;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        if (rx_valid) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (done_flag) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_RDADDR;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
      S_RDADDR: state_d = S_RDWAIT;
      S_RDWAIT: begin
        tx_data_d = read_data[7:0];
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            job_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RDADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; everything idles at zero so reset clears them at once.
  always_comb begin
    rx_ready         = 1'b0;
    cpu_en           = 2'b00;
    program_sel      = 2'b00;
    char_buffer_data = 8'h00;
    shift_amt_data   = 5'd0;
    read_addr        = 12'd0;
    tx_valid         = 1'b0;
    case (state_q)
      S_FILL: begin
        rx_ready    = 1'b1;
        program_sel = mode_q;
      end
      S_WRITE: begin
        cpu_en           = 2'b01;
        program_sel      = mode_q;
        char_buffer_data = buf_mem[buf_addr];
        if (idx_q == IDX_LAST) begin
          shift_amt_data = shift_q;
        end
      end
      S_EXEC: begin
        cpu_en      = 2'b10;
        program_sel = mode_q;
      end
      S_RDADDR, S_RDWAIT: read_addr = RAM_BASE12 + 12'(idx_q);
      S_SEND:             tx_valid  = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign tx_data  = tx_data_q;
  assign job_done = job_done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_decrypt_sequencer.sv
`timescale 1ns/1ps
// tb_decrypt_sequencer: random jobs against a queue-based reference of the job contract.
// Instance a uses the default sizes; instance b is small, 12-bit address wrap, 64-cycle timeout.
module tb_decrypt_sequencer;

  localparam int BL    = 108;
  localparam int BASE  = 1500;
  localparam int BL2   = 8;
  localparam int BASE2 = 4090;
  localparam int TO2   = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [1:0]  mode_in = 2'b00;
  logic [4:0]  shift_in = 5'd0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        done_flag = 1'b0;
  logic [31:0] read_data = 32'h0;
  logic        tx_ready = 1'b0;
  logic        sel = 1'b0;

  logic        a_rxr, a_txv, a_busy, a_jd, a_to;
  logic [7:0]  a_cbd, a_txd;
  logic [1:0]  a_cpu, a_ps;
  logic [4:0]  a_sh;
  logic [11:0] a_ra;
  logic        b_rxr, b_txv, b_busy, b_jd, b_to;
  logic [7:0]  b_cbd, b_txd;
  logic [1:0]  b_cpu, b_ps;
  logic [4:0]  b_sh;
  logic [11:0] b_ra;

  decrypt_sequencer #(.BUF_LEN(BL), .RAM_BASE(BASE), .TIMEOUT_CYCLES(1048576)) dut_a (
    .clock(clock), .reset(reset), .start(start), .mode_in(mode_in), .shift_in(shift_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(a_rxr), .char_buffer_data(a_cbd),
    .cpu_en(a_cpu), .program_sel(a_ps), .shift_amt_data(a_sh), .done_flag(done_flag),
    .read_addr(a_ra), .read_data(read_data), .tx_data(a_txd), .tx_valid(a_txv),
    .tx_ready(tx_ready), .busy(a_busy), .job_done(a_jd), .timeout(a_to));

  decrypt_sequencer #(.BUF_LEN(BL2), .RAM_BASE(BASE2), .TIMEOUT_CYCLES(TO2)) dut_b (
    .clock(clock), .reset(reset), .start(start2), .mode_in(mode_in), .shift_in(shift_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(b_rxr), .char_buffer_data(b_cbd),
    .cpu_en(b_cpu), .program_sel(b_ps), .shift_amt_data(b_sh), .done_flag(done_flag),
    .read_addr(b_ra), .read_data(read_data), .tx_data(b_txd), .tx_valid(b_txv),
    .tx_ready(tx_ready), .busy(b_busy), .job_done(b_jd), .timeout(b_to));

  // Observed instance, chosen by sel.
  wire        m_rxr  = sel ? b_rxr  : a_rxr;
  wire        m_txv  = sel ? b_txv  : a_txv;
  wire        m_busy = sel ? b_busy : a_busy;
  wire        m_jd   = sel ? b_jd   : a_jd;
  wire        m_to   = sel ? b_to   : a_to;
  wire [7:0]  m_cbd  = sel ? b_cbd  : a_cbd;
  wire [7:0]  m_txd  = sel ? b_txd  : a_txd;
  wire [1:0]  m_cpu  = sel ? b_cpu  : a_cpu;
  wire [1:0]  m_ps   = sel ? b_ps   : a_ps;
  wire [4:0]  m_sh   = sel ? b_sh   : a_sh;
  wire [11:0] m_ra   = sel ? b_ra   : a_ra;

  always #5 clock = ~clock;

  // Data RAM model: registered read, word valid one cycle after the address.
  logic [31:0] ram [4096];
  always @(posedge clock) read_data <= ram[m_ra];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: accumulates what the observed instance did, sampled on the falling edge.
  int         n_wr = 0, n_exec = 0, n_shift = 0, shift_pos = -1, n_jd = 0, n_unstable = 0, n_ps_bad = 0;
  logic [4:0] shift_val = 5'd0;
  logic [1:0] exp_mode = 2'b00;
  logic [7:0] wrq [$];
  logic [7:0] txq [$];
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  always @(negedge clock) begin
    if (m_sh != 5'd0) begin
      n_shift++;
      shift_pos = (m_cpu == 2'b01) ? n_wr : -1;
      shift_val = m_sh;
    end
    if (m_cpu == 2'b01) begin
      wrq.push_back(m_cbd);
      n_wr++;
    end
    if (m_cpu == 2'b10) n_exec++;
    if (m_jd) n_jd++;
    if (m_busy && (m_rxr || m_cpu != 2'b00) && m_ps != exp_mode) n_ps_bad++;
    if (!m_busy && m_ps != 2'b00) n_ps_bad++;
    if (hold_v && m_txv && m_txd !== hold_d) n_unstable++;
    hold_v = m_txv && !tx_ready;
    hold_d = m_txd;
    if (m_txv && tx_ready) txq.push_back(m_txd);
  end

  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_ctrl"}, 32'({m_busy, m_cpu, m_ps, m_txv, m_rxr, m_jd, m_to, m_sh}), 32'd0);
    chk({tag, "_data"}, 32'({m_ra, m_txd, m_cbd}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    chk({tag, "_idle"}, 32'(m_busy), 32'd0);
  endtask

  // abort: 0 normal, 1 reset in EXEC, 2 reset in SEND, 3 expect timeout (done never raised)
  task automatic run_job(input logic s, input logic [1:0] md, input logic [4:0] sh, input int n,
                         input int base, input int dly, input bit ascii, input bit rnd,
                         input bit bp, input int abort);
    logic [7:0] bytes [$];
    int i, guard, wr0, ex0, sh0, jd0, un0, ps0, tx0;
    logic acc;
    sel = s;
    exp_mode = md;
    wr0 = n_wr; ex0 = n_exec; sh0 = n_shift; jd0 = n_jd; un0 = n_unstable; ps0 = n_ps_bad; tx0 = txq.size();
    for (int k = 0; k < n; k++) bytes.push_back(ascii ? 8'(8'h41 + k) : 8'($urandom));
    mode_in = md; shift_in = sh;
    if (s) start2 = 1'b1; else start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; start2 = 1'b0; mode_in = 2'b00; shift_in = 5'd0;
    chk("start_busy", 32'(m_busy), 32'd1);
    chk("start_clears_timeout", 32'(m_to), 32'd0);
    i = 0; guard = 0;
    while (i < n && guard < 20 * n + 100) begin
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data  = bytes[i];
      if (rnd && i == n / 2) begin
        mode_in = (md == 2'b01) ? 2'b10 : 2'b01;
        if (s) start2 = 1'b1; else start = 1'b1;
      end
      acc = rx_valid && m_rxr;
      @(posedge clock); #1;
      start = 1'b0; start2 = 1'b0; mode_in = 2'b00;
      if (acc) i++;
      guard++;
    end
    rx_valid = 1'b0;
    chk("fill_count", 32'(i), 32'(n));
    guard = 0;
    while (m_cpu != 2'b10 && guard < n + 20) begin @(posedge clock); #1; guard++; end
    chk("exec_reached", 32'(m_cpu), 32'd2);
    chk("write_cycles", 32'(n_wr - wr0), 32'(n));
    for (int k = 0; k < n; k++)
      chk("write_byte", (wr0 + k < wrq.size()) ? 32'(wrq[wr0 + k]) : 32'hFFFF_FFFF, 32'(bytes[k]));
    chk("shift_pulses", 32'(n_shift - sh0), (sh != 5'd0) ? 32'd1 : 32'd0);
    if (sh != 5'd0) begin
      chk("shift_last_write", 32'(shift_pos), 32'(wr0 + n - 1));
      chk("shift_value", 32'(shift_val), 32'(sh));
    end
    if (abort == 1) begin
      repeat (dly) begin @(posedge clock); #1; end
      mid_reset("rst_exec");
      return;
    end
    if (abort == 3) begin
      guard = 0;
      while (m_busy && guard < TO2 + 20) begin @(posedge clock); #1; guard++; end
      chk("timeout_exec_cycles", 32'(n_exec - ex0), 32'(TO2));
      chk("timeout_flag", 32'(m_to), 32'd1);
      chk("timeout_idle", 32'(m_busy), 32'd0);
      repeat (5) begin @(posedge clock); #1; end
      chk("timeout_sticky", 32'(m_to), 32'd1);
      chk("timeout_no_done", 32'(n_jd - jd0), 32'd0);
      return;
    end
    repeat (dly) begin @(posedge clock); #1; end
    done_flag = 1'b1;
    @(posedge clock); #1;
    done_flag = 1'b0;
    chk("exec_cycles", 32'(n_exec - ex0), 32'(dly + 1));
    i = 0; guard = 0;
    while (i < n && guard < n * 40) begin
      if (m_txv) begin
        if (abort == 2 && i == 3) begin
          mid_reset("rst_send");
          return;
        end
        if (bp) repeat (10) begin @(posedge clock); #1; guard++; end
        tx_ready = 1'b1;
        @(posedge clock); #1;
        tx_ready = 1'b0;
        i++;
      end else begin
        @(posedge clock); #1;
      end
      guard++;
    end
    repeat (3) begin @(posedge clock); #1; end
    chk("job_done_pulses", 32'(n_jd - jd0), 32'd1);
    chk("end_idle", 32'(m_busy), 32'd0);
    chk("tx_count", 32'(txq.size() - tx0), 32'(n));
    for (int k = 0; k < n; k++)
      chk("tx_byte", (tx0 + k < txq.size()) ? 32'(txq[tx0 + k]) : 32'hFFFF_FFFF,
          32'(ram[(base + k) % 4096][7:0]));
    chk("tx_stable", 32'(n_unstable - un0), 32'd0);
    chk("program_sel", 32'(n_ps_bad - ps0), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4096; k++) ram[k] = $urandom;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl", 32'({a_busy, a_cpu, a_ps, a_txv, a_rxr, a_jd, a_to, a_sh}), 32'd0);
    chk("reset_data", 32'({a_ra, a_txd, a_cbd}), 32'd0);
    reset = 1'b0;
    // Traffic without a start must not wake the sequencer.
    for (int k = 0; k < 6; k++) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      mode_in  = 2'($urandom);
      @(posedge clock); #1;
    end
    rx_valid = 1'b0; mode_in = 2'b00;
    chk("idle_no_start", 32'({a_busy, b_busy}), 32'd0);
    // Start with an illegal mode is ignored.
    for (int k = 0; k < 2; k++) begin
      mode_in = (k == 0) ? 2'b00 : 2'b11;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("illegal_mode", 32'({a_busy, a_ps, a_rxr}), 32'd0);
    end
    mode_in = 2'b00;
    run_job(1'b0, 2'b01, 5'd3,  BL,  BASE,  500, 1'b1, 1'b0, 1'b0, 0);
    run_job(1'b0, 2'b10, 5'd0,  BL,  BASE,  20,  1'b0, 1'b1, 1'b1, 0);
    run_job(1'b1, 2'b01, 5'd5,  BL2, BASE2, 0,   1'b0, 1'b0, 1'b0, 3);
    run_job(1'b1, 2'b10, 5'd31, BL2, BASE2, 10,  1'b0, 1'b1, 1'b0, 0);
    run_job(1'b0, 2'b01, 5'd7,  BL,  BASE,  30,  1'b0, 1'b0, 1'b0, 1);
    run_job(1'b0, 2'b01, 5'd7,  BL,  BASE,  30,  1'b0, 1'b0, 1'b0, 2);
    run_job(1'b0, 2'b10, 5'd1,  BL,  BASE,  40,  1'b0, 1'b1, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decrypt_sequencer.md
DECRYPT_SEQUENCER -- requirements
Module: decrypt_sequencer

Interface
REQ-001 SHALL have parameter BUF_LEN, default 108, giving the character count per job (12x9 buffer).
REQ-002 SHALL have parameter RAM_BASE, default 1500, giving the first data-RAM word address of the character buffer.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576, giving the maximum number of EXEC cycles before abort.
REQ-004 SHALL have the following ports, one per line as name, direction, width, meaning:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle job request.
- mode_in  in  2  program select to capture: 01 = EN, 10 = BF.
- shift_in  in  5  shift amount to capture.
- rx_data  in  8  incoming character byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  sequencer accepts a byte.
- char_buffer_data  out  8  character to processor wrapper.
- cpu_en  out  2  00 IDLE, 01 WRITE, 10 EXEC.
- program_sel  out  2  captured mode.
- shift_amt_data  out  5  shift value to wrapper (nonzero forces register 6 write).
- done_flag  in  1  wrapper read_regA[0]; high when the program sets r28 = 1.
- read_addr  out  12  RAM readback address.
- read_data  in  32  RAM readback word; valid one cycle after read_addr.
- tx_data  out  8  result byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts a byte.
- busy  out  1  high in every state except IDLE.
- job_done  out  1  one-cycle pulse at job completion.
- timeout  out  1  sticky abort flag.

Function
REQ-005 SHALL implement the states IDLE, FILL, WRITE, EXEC, RDADDR, RDWAIT, SEND, with a single index counter idx (7 bits minimum) and a TIMEOUT_CYCLES-wide counter.
REQ-006 IDLE: on start=1 with mode_in equal to 01 or 10, SHALL capture mode_in and shift_in, clear timeout, set idx=0, and go to FILL; start is ignored for any other mode_in value and in every non-IDLE state.
REQ-007 FILL: rx_ready=1; on rx_valid&rx_ready SHALL store rx_data in an internal BUF_LEN x 8 buffer at idx and increment idx; after the BUF_LEN-th byte SHALL set idx=0 and go to WRITE. rx_ready=0 in all other states.
REQ-008 WRITE: cpu_en=01 for exactly BUF_LEN consecutive cycles; char_buffer_data=buf[idx] combinationally, and idx increments every cycle; then SHALL go to EXEC.
REQ-009 shift_amt_data SHALL equal the captured shift only in the last WRITE cycle, and 0 otherwise; a captured shift of 0 therefore produces no register 6 write.
REQ-010 program_sel SHALL hold the captured mode from FILL through EXEC, and be 00 in IDLE.
REQ-011 EXEC: cpu_en=10 and the timeout counter increments each cycle; on done_flag=1, SHALL set idx=0 and go to RDADDR; on the counter reaching TIMEOUT_CYCLES with done_flag=0, SHALL set timeout=1 and go to IDLE with no job_done pulse; if both occur in the same cycle, done_flag wins.
REQ-012 RDADDR/RDWAIT: cpu_en=00, read_addr=RAM_BASE+idx (12-bit, wraps modulo 4096); SHALL spend one cycle in RDWAIT, then latch read_data[7:0] into tx_data and go to SEND.
REQ-013 SEND: tx_valid=1 with tx_data held stable until tx_ready=1; on acceptance SHALL increment idx, and then either go to RDADDR, or after BUF_LEN bytes pulse job_done for one cycle and go to IDLE.
REQ-014 cpu_en SHALL be 00 in IDLE, FILL, RDADDR, RDWAIT, SEND; read_addr SHALL be 0 outside RDADDR/RDWAIT.

Reset
REQ-015 reset=1 SHALL immediately force IDLE, idx=0, counters=0, and all outputs 0, including timeout, regardless of state or in-flight handshakes.
REQ-016 After reset deasserts, the first action SHALL occur no earlier than the first rising edge at which start=1.

Verification
REQ-017 Full job: mode 01, shift 3, 108 bytes 0x41..; processor raises done_flag after 500 cycles -> cpu_en=01 for exactly 108 cycles, shift_amt_data=3 for exactly one cycle, 108 tx bytes equal to RAM[1500..1607][7:0], one job_done pulse.
REQ-018 Backpressure: rx_valid toggles randomly in FILL and tx_ready held low for 10 cycles per byte in SEND -> no lost or duplicated byte, tx_data stable while tx_valid=1 and tx_ready=0.
REQ-019 Timeout: TIMEOUT_CYCLES=64, done_flag held at 0 -> timeout=1 after 64 EXEC cycles, state IDLE, job_done never asserts, next start clears timeout.
REQ-020 Reset mid-EXEC and mid-SEND -> all outputs 0 asynchronously; a fresh job then completes correctly.
REQ-021 Illegal start: start with mode_in=00 or 11, and start pulses while busy -> no state change, busy unchanged.
